// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: streams an HxW raster image into an external image
// buffer, then walks every 3x3 window top-left address in raster order and
// presents each one with a valid/ready handshake.
module window_scan_ctrl #(
  parameter int unsigned MAX_DIM = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] H,
  input  logic [15:0] W,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] write_H,
  output logic [15:0] write_W,
  output logic [7:0]  write_data,
  output logic        mem_ready,
  output logic [15:0] read_H,
  output logic [15:0] read_W,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [15:0] win_row,
  output logic [15:0] win_col,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] MAX_DIM_L = 16'(MAX_DIM);

  state_t      state_q, state_d;
  logic [15:0] h_q, h_d;
  logic [15:0] w_q, w_d;
  logic [15:0] write_h_q, write_h_d;
  logic [15:0] write_w_q, write_w_d;
  logic [15:0] nr_q, nr_d;
  logic [15:0] nc_q, nc_d;
  logic [15:0] win_row_q, win_row_d;
  logic [15:0] win_col_q, win_col_d;
  logic        win_valid_q, win_valid_d;
  logic        err_q, err_d;
  logic        stall_s;

  // A presented window that is not consumed holds the scan in place.
  assign stall_s = win_valid_q && !win_ready;

  // Next-state and next-counter logic for the load/scan sequencer.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    w_d         = w_q;
    write_h_d   = write_h_q;
    write_w_d   = write_w_q;
    nr_d        = nr_q;
    nc_d        = nc_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_valid_d = win_valid_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          h_d       = H;
          w_d       = W;
          err_d     = 1'b0;
          write_h_d = 16'd0;
          write_w_d = 16'd0;
          nr_d      = 16'd0;
          nc_d      = 16'd0;
          if ((H > MAX_DIM_L) || (W > MAX_DIM_L)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if ((H == 16'd0) || (W == 16'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // pix_ready is 1 throughout LOAD, so pix_valid alone is an accept.
        if (pix_valid) begin
          if (write_w_q == (w_q - 16'd1)) begin
            write_w_d = 16'd0;
            if (write_h_q == (h_q - 16'd1)) begin
              write_h_d = 16'd0;
              state_d   = S_SCAN;
            end else begin
              write_h_d = write_h_q + 16'd1;
            end
          end else begin
            write_w_d = write_w_q + 16'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_SCAN: begin
        // Images smaller than 3 in either dimension have no windows; the
        // H-3 / W-3 terms below are only reached once both are >= 3.
        if ((h_q < 16'd3) || (w_q < 16'd3)) begin
          state_d = S_DONE;
        end else if (!stall_s) begin
          win_valid_d = 1'b1;
          win_row_d   = nr_q;
          win_col_d   = nc_q;
          if (nc_q == (w_q - 16'd3)) begin
            nc_d = 16'd0;
            if (nr_q == (h_q - 16'd3)) begin
              nr_d    = 16'd0;
              state_d = S_DRAIN;
            end else begin
              nr_d = nr_q + 16'd1;
            end
          end else begin
            nc_d = nc_q + 16'd1;
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DRAIN: begin
        if (win_valid_q && win_ready) begin
          win_valid_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h_q         <= 16'd0;
      w_q         <= 16'd0;
      write_h_q   <= 16'd0;
      write_w_q   <= 16'd0;
      nr_q        <= 16'd0;
      nc_q        <= 16'd0;
      win_row_q   <= 16'd0;
      win_col_q   <= 16'd0;
      win_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      w_q         <= w_d;
      write_h_q   <= write_h_d;
      write_w_q   <= write_w_d;
      nr_q        <= nr_d;
      nc_q        <= nc_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_valid_q <= win_valid_d;
      err_q       <= err_d;
    end
  end

  // Buffer mode follows the state; a stalled window re-reads its own address
  // so the buffer's 3x3 output stays stable until consumed.
  assign pix_ready  = (state_q == S_LOAD);
  assign mem_ready  = (state_q != S_LOAD);
  assign write_data = pix_in;
  assign write_H    = write_h_q;
  assign write_W    = write_w_q;
  assign read_H     = stall_s ? win_row_q : nr_q;
  assign read_W     = stall_s ? win_col_q : nc_q;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule
